caliptra_prim_packer_arb: RTL and testbench

- Round-robin arbiter that shares one pack-mode packer FIFO (narrow in, wide out) between NumReq narrow requesters.
- Grant is held for exactly one full output word (Ratio input beats), so beats from different requesters never mix inside a word.
- Grant is released only after the packer has drained the word.
- Publishes the owner index of the word currently being built or presented, so the wide-side consumer can tag it.

---
 rtl/caliptra_prim_packer_arb_pkg.sv | 14 +
 rtl/caliptra_prim_packer_arb_rr.sv | 32 +++
 rtl/caliptra_prim_packer_arb.sv | 111 +++++++++++
 tb/tb_caliptra_prim_packer_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/caliptra_prim_packer_arb_pkg.sv
// caliptra_prim_packer_arb_pkg: shared FSM encoding and sizing helper for the packer arbiter
package caliptra_prim_packer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } packer_arb_state_e;

    function automatic int calc_ratio(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

endpackage

// File: rtl/caliptra_prim_packer_arb_rr.sv
// caliptra_prim_packer_arb_rr: combinational round-robin picker
//   req       - request vector
//   ptr       - index the upward search starts from (wraps at NumReq)
//   winner    - first set request at or above ptr, wrapping
//   any_valid - at least one request set
module caliptra_prim_packer_arb_rr #(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   winner,
    output logic              any_valid
);

    function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        return IdxW'(j >= NumReq ? j - NumReq : j);
    endfunction

    // Scan from the farthest candidate back to ptr so the closest one wins.
    always_comb begin
        winner = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)]) winner = wrap_idx(ptr, k);
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/caliptra_prim_packer_arb.sv
// caliptra_prim_packer_arb: round-robin share of one pack-mode packer between NumReq narrow requesters
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   clr_i           - synchronous clear, highest priority
//   req_valid_i/req_data_i/req_ready_o - per-requester narrow beat interface
//   pk_wvalid_o/pk_wdata_o/pk_wready_i - packer write side; pk_clr_o clears the packer
//   owner_o/owner_valid_o - requester owning the word being built or presented
//   err_o           - stall-timeout abort pulse
// Optional: define CALIPTRA_PACKER_ARB_TIMEOUT_EN to abort a word whose owner stalls TimeoutCycles.
module caliptra_prim_packer_arb
    import caliptra_prim_packer_arb_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int InW           = 8,
    parameter int OutW          = 32,
    parameter int TimeoutCycles = 64,
    localparam int Ratio        = calc_ratio(OutW, InW),
    localparam int IdxW         = $clog2(NumReq),
    localparam int CntW         = $clog2(Ratio)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*InW-1:0] req_data_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  pk_wvalid_o,
    output logic [InW-1:0]        pk_wdata_o,
    input  logic                  pk_wready_i,
    output logic                  pk_clr_o,
    output logic [IdxW-1:0]       owner_o,
    output logic                  owner_valid_o,
    output logic                  err_o
);

    if (NumReq < 2 || OutW <= InW || Ratio < 2 || Ratio * InW != OutW ||
        (Ratio & (Ratio - 1)) != 0 || TimeoutCycles < 1) begin : g_cfg_err
        $error("caliptra_prim_packer_arb: invalid parameter set");
    end

    packer_arb_state_e state;
    logic [IdxW-1:0]   owner, rr_ptr, pick, next_owner;
    logic [CntW-1:0]   cnt;
    logic              any, active, hs, abort;

    caliptra_prim_packer_arb_rr #(.NumReq(NumReq), .IdxW(IdxW)) u_rr (
        .req      (req_valid_i),
        .ptr      (rr_ptr),
        .winner   (pick),
        .any_valid(any)
    );

    // Explicit wrap so non-power-of-two NumReq never points past the last requester.
    assign next_owner = (owner == IdxW'(NumReq - 1)) ? '0 : owner + IdxW'(1);
    assign active     = state == PACK && !clr_i && !abort;
    assign hs         = active && req_valid_i[owner] && pk_wready_i;

`ifdef CALIPTRA_PACKER_ARB_TIMEOUT_EN
    localparam int TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] stall;
    assign abort = state == PACK && stall == TmoW'(TimeoutCycles);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall <= '0;
        else stall <= (clr_i || abort || hs || state != PACK) ? '0 :
                      !req_valid_i[owner] ? stall + TmoW'(1) : stall;
    end
`else
    assign abort = 1'b0;
`endif

    assign req_ready_o   = (active && pk_wready_i) ? (NumReq'(1) << owner) : '0;
    assign pk_wvalid_o   = active && req_valid_i[owner];
    assign pk_wdata_o    = active ? req_data_i[int'(owner) * InW +: InW] : '0;
    assign pk_clr_o      = clr_i || abort;
    assign err_o         = abort && !clr_i;
    assign owner_o       = owner;
    assign owner_valid_o = state != IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else if (clr_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
        end else if (abort) begin
            state  <= IDLE;
            rr_ptr <= next_owner;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    owner <= pick;
                    state <= PACK;
                end
                PACK: if (hs) begin
                    cnt <= cnt + CntW'(1);
                    if (cnt == CntW'(Ratio - 1)) state <= DRAIN;
                end
                DRAIN: if (pk_wready_i) begin
                    rr_ptr <= next_owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_caliptra_prim_packer_arb.sv
// tb_caliptra_prim_packer_arb: directed bench with a word-level reference model for caliptra_prim_packer_arb
module tb_caliptra_prim_packer_arb;
    localparam int N = 4, W = 8, R = 4, TMO = 8;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, wready = 1'b0;
    logic [N-1:0] valid = '0;
    logic [N*W-1:0] data;
    logic [N-1:0] ready;
    logic wvalid, pk_clr, ov, err;
    logic [W-1:0] wdata;
    logic [1:0] owner;

    int checks = 0, errors = 0, err_cnt = 0;
    int seq [N] = '{default: 0};
    int m_phase = 0, m_owner = 0, m_beats = 0, m_ptr = 0, m_stall = 0;
    logic [31:0] m_word = '0;
    logic [31:0] m_words [$];
    int d_grants [$];
    logic [7:0] d_beats [$];
    logic ov_prev = 1'b0;

    caliptra_prim_packer_arb #(.NumReq(N), .InW(W), .OutW(32), .TimeoutCycles(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .req_valid_i(valid), .req_data_i(data), .req_ready_o(ready),
        .pk_wvalid_o(wvalid), .pk_wdata_o(wdata), .pk_wready_i(wready),
        .pk_clr_o(pk_clr), .owner_o(owner), .owner_valid_o(ov), .err_o(err)
    );

    always #5 clk = ~clk;

    // Requester i's s-th beat; requester 0 yields 0x11,0x22,0x33,0x44.
    function automatic logic [7:0] d(input int i, input int s);
        return 8'(i * 64 + (s + 1) * 17);
    endfunction

    always_comb for (int i = 0; i < N; i++) data[i*W +: W] = d(i, seq[i]);

    function automatic bit m_abort();
`ifdef CALIPTRA_PACKER_ARB_TIMEOUT_EN
        return m_phase == 1 && m_stall == TMO;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (d_beats.size() < n && t < 100) begin tick(); t++; end
        chk("beat_wait", 32'(d_beats.size() >= n), 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (ov && t < 100) begin tick(); t++; end
        chk("idle_wait", 32'(ov), 0);
    endtask

    // Reference model: phase 0 = no owner, 1 = collecting beats, 2 = word waiting to be read.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_stall = 0;
        end else if (clr) begin
            m_phase = 0; m_beats = 0; m_ptr = 0; m_stall = 0;
        end else if (m_abort()) begin
            m_phase = 0; m_beats = 0; m_ptr = (m_owner + 1) % N; m_stall = 0;
        end else if (m_phase == 0) begin
            if (valid != 0) begin
                bit found;
                found = 0;
                for (int k = 0; k < N; k++)
                    if (!found && valid[(m_ptr + k) % N]) begin m_owner = (m_ptr + k) % N; found = 1; end
                m_phase = 1; m_stall = 0;
            end
        end else if (m_phase == 1) begin
            if (valid[m_owner] && wready) begin
                m_word[m_beats*W +: W] = d(m_owner, seq[m_owner]);
                m_stall = 0;
                m_beats++;
                if (m_beats == R) begin m_words.push_back(m_word); m_beats = 0; m_phase = 2; end
            end else if (!valid[m_owner]) m_stall++;
        end else if (wready) begin
            m_ptr = (m_owner + 1) % N; m_phase = 0;
        end
    end

    // Requesters advance to their next beat after each accepted handshake.
    initial forever begin
        logic [N-1:0] hs;
        @(negedge clk);
        hs = valid & ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) seq[i]++;
    end

    // Per-cycle compare against the model, plus monitors feeding the directed checks.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            bit act;
            act = m_phase == 1 && !clr && !m_abort();
            chk("ready", 32'(ready), (act && wready) ? 32'(1 << m_owner) : 32'd0);
            chk("wvalid", 32'(wvalid), 32'(act && valid[m_owner]));
            if (act && valid[m_owner]) chk("wdata", 32'(wdata), 32'(d(m_owner, seq[m_owner])));
            chk("pk_clr", 32'(pk_clr), 32'(clr || m_abort()));
            chk("err", 32'(err), 32'(m_abort() && !clr));
            chk("owner_valid", 32'(ov), 32'(m_phase != 0));
            if (m_phase != 0) chk("owner", 32'(owner), 32'(m_owner));
            if (wvalid && wready) d_beats.push_back(wdata);
            if (ov && !ov_prev) d_grants.push_back(int'(owner));
            if (err) err_cnt++;
        end
        ov_prev = ov;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        int exp_grants [5] = '{0, 1, 2, 3, 0};
        #1;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_pk_clr", 32'(pk_clr), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_ov", 32'(ov), 0);
        chk("rst_err", 32'(err), 0);
        tick(2);
        rst_n = 1'b1;

        // Single word from req0.
        wready = 1'b1; valid = 4'b0001; d_beats.delete();
        wait_beats(4);
        valid = '0; wready = 1'b0;
        chk("t1_owner", 32'(owner), 0);
        chk("t1_ov_drain", 32'(ov), 1);
        chk("t1_ready_drain", 32'(ready), 0);
        chk("t1_word", {d_beats[3], d_beats[2], d_beats[1], d_beats[0]}, 32'h44332211);
        chk("t1_model_word", m_words[$], 32'h44332211);
        tick(3);
        chk("t1_hold_drain", 32'(ov), 1);
        wready = 1'b1;
        tick();
        chk("t1_drain_exit", 32'(ov), 0);

        // All requesters valid: rotation from 0.
        clr = 1'b1; tick(); clr = 1'b0;
        d_grants.delete(); valid = 4'hf;
        for (int t = 0; t < 200 && d_grants.size() < 5; t++) tick();
        valid = 4'b0001;
        wait_idle();
        valid = '0;
        chk("t2_grant_cnt", 32'(d_grants.size()), 5);
        for (int i = 0; i < 5; i++) chk("t2_grant", 32'(d_grants[i]), 32'(exp_grants[i]));

        // req2 pauses mid-word; grant is held.
        valid = 4'b0100; d_beats.delete();
        wait_beats(2);
        valid = 4'b1010;
        tick(10);
        chk("t3_owner_hold", 32'(owner), 2);
        chk("t3_others_ready", 32'(ready & 4'b1010), 0);
        valid = 4'b1110;
        wait_beats(4);
        chk("t3_owner_end", 32'(owner), 2);
        chk("t3_drain", 32'(ov), 1);

        // clr on req1's third beat.
        valid = 4'b0010; d_beats.delete();
        wait_beats(2);
        chk("t4_owner", 32'(owner), 1);
        clr = 1'b1;
        #1;
        chk("t4_pk_clr", 32'(pk_clr), 1);
        chk("t4_ready", 32'(ready), 0);
        chk("t4_wvalid", 32'(wvalid), 0);
        tick();
        clr = 1'b0;
        chk("t4_idle", 32'(ov), 0);
        chk("t4_no_beat", 32'(d_beats.size()), 2);
        valid = 4'b0011;
        tick();
        chk("t4_regrant", 32'(owner), 0);
        chk("t4_regrant_ov", 32'(ov), 1);

        // Owner stalls mid-word.
        valid = 4'b0001; d_beats.delete();
        wait_beats(2);
        valid = '0; err_cnt = 0;
        tick(12);
`ifdef CALIPTRA_PACKER_ARB_TIMEOUT_EN
        chk("t5_err_pulses", 32'(err_cnt), 1);
        chk("t5_released", 32'(ov), 0);
        valid = 4'b0010;
        tick();
        chk("t5_next_owner", 32'(owner), 1);
        wait_idle();
`else
        chk("t5_no_err", 32'(err_cnt), 0);
        chk("t5_held", 32'(ov), 1);
        chk("t5_owner", 32'(owner), 0);
        valid = 4'b0001;
        wait_idle();
`endif
        valid = '0;

        // Async reset while in DRAIN.
        valid = 4'b0100; wready = 1'b1; d_beats.delete();
        wait_beats(4);
        wready = 1'b0; valid = '0;
        chk("t6_in_drain", 32'(ov), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ov", 32'(ov), 0);
        chk("t6_owner", 32'(owner), 0);
        chk("t6_ready", 32'(ready), 0);
        chk("t6_wvalid", 32'(wvalid), 0);
        chk("t6_err", 32'(err), 0);
        tick();
        rst_n = 1'b1; valid = 4'b1001; wready = 1'b1;
        tick();
        chk("t6_from_req0", 32'(owner), 0);
        valid = 4'b0001;
        wait_idle();
        valid = '0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
